// File: rtl/pool2d_engine_if.sv
// Control and memory-port bundle for pool2d_engine.
// The master side is the host and memory model; the slave side is the engine.
interface pool2d_engine_if #(
  parameter int DW = 12,
  parameter int AW = 12
);
  logic          start;
  logic          mode;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output start, mode, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, mode, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool2d_engine.sv
// 2x2 stride-2 max/average pooling over a CH x IN_H x IN_W map.
// Streams one read per cycle in window order and writes one result per window.
module pool2d_engine #(
  parameter int DW   = 12,
  parameter int IN_W = 28,
  parameter int IN_H = 28,
  parameter int CH   = 1,
  parameter int AW   = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  pool2d_engine_if.slave   bus
);

  localparam int OW     = IN_W / 2;
  localparam int OH     = IN_H / 2;
  localparam int PLANE  = IN_W * IN_H;
  localparam int XW     = (OW > 1) ? $clog2(OW) : 1;
  localparam int YW     = (OH > 1) ? $clog2(OH) : 1;
  localparam int CW     = (CH > 1) ? $clog2(CH) : 1;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   c;
  logic [YW-1:0]   oy;
  logic [XW-1:0]   ox;
  logic [1:0]      sub;
  logic [1:0]      s1_sub;
  logic [STAGES:0] vld_pipe;
  logic            mode_q;
  logic            busy;
  logic            done;
  logic            wr_en;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   wr_cnt;
  logic [DW-1:0]   wr_data;
  logic [DW+1:0]   acc;
  logic [DW+1:0]   prev;
  logic [DW+1:0]   samp;
  logic [DW+1:0]   nxt;
  logic            last_rd;

  // Counters always describe the read presented on the bus this cycle.
  assign last_rd = (sub == 2'd3) && (ox == XW'(OW - 1)) &&
                   (oy == YW'(OH - 1)) && (c == CW'(CH - 1));

  always_comb begin
    rd_addr = AW'(32'(c) * PLANE + (32'(oy) * 2 + 32'(sub[1])) * IN_W +
                  32'(ox) * 2 + 32'(sub[0]));
  end

  // First sample of a window ignores the accumulator so windows never mix.
  always_comb begin
    samp = {2'b00, bus.rd_data};
    prev = (s1_sub == 2'd0) ? '0 : acc;
    if (mode_q) nxt = prev + samp;
    else        nxt = (samp > prev) ? samp : prev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      c        <= '0;
      oy       <= '0;
      ox       <= '0;
      sub      <= '0;
      s1_sub   <= '0;
      vld_pipe <= '0;
      mode_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_cnt   <= '0;
      wr_data  <= '0;
      acc      <= '0;
    end else begin
      done                 <= 1'b0;
      wr_en                <= 1'b0;
      vld_pipe[STAGES:1]   <= vld_pipe[STAGES-1:0];
      s1_sub               <= sub;

      // Stage 1: read data has returned; fold it into the window result.
      if (vld_pipe[STAGES]) begin
        if (s1_sub == 2'd3) begin
          wr_en   <= 1'b1;
          wr_addr <= wr_cnt;
          wr_cnt  <= wr_cnt + 1'b1;
          wr_data <= mode_q ? nxt[DW+1:2] : nxt[DW-1:0];
          acc     <= '0;
        end else begin
          acc <= nxt;
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= READ;
            busy        <= 1'b1;
            mode_q      <= bus.mode;
            vld_pipe[0] <= 1'b1;
            wr_cnt      <= '0;
          end
        end
        READ: begin
          sub <= sub + 1'b1;
          if (sub == 2'd3) begin
            if (ox == XW'(OW - 1)) begin
              ox <= '0;
              if (oy == YW'(OH - 1)) begin
                oy <= '0;
                c  <= (c == CW'(CH - 1)) ? '0 : c + 1'b1;
              end else begin
                oy <= oy + 1'b1;
              end
            end else begin
              ox <= ox + 1'b1;
            end
          end
          if (last_rd) begin
            vld_pipe[0] <= 1'b0;
            state       <= DRAIN;
          end
        end
        // Final write is the one issued once the data stage has emptied.
        DRAIN: begin
          if (wr_en && !vld_pipe[STAGES]) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.rd_en   = vld_pipe[0];
  assign bus.rd_addr = rd_addr;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;

endmodule

// File: tb/tb_pool2d_engine.sv
// Scoreboard bench: a 4x4x2 engine checked read-by-read and write-by-write,
// plus a default 28x28 engine checked for pass timing and counts.
module tb_pool2d_engine;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  pool2d_engine_if #(.DW(12), .AW(12)) b ();
  pool2d_engine_if #(.DW(12), .AW(12)) bb ();

  pool2d_engine #(.DW(12), .IN_W(4), .IN_H(4), .CH(2), .AW(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b.slave)
  );

  pool2d_engine #(.DW(12), .IN_W(28), .IN_H(28), .CH(1), .AW(12)) u_big (
    .clk(clk), .rst_n(rst_n), .bus(bb.slave)
  );

  typedef struct { int addr; int data; } wexp_t;

  logic [11:0] mem [32];
  int          rq[$];
  wexp_t       wq[$];
  int          win_order[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int          ed[8];
  int          rd_cnt = 0;
  int          start_cyc = 0;
  int          lat;
  int          big_start = 0, big_rd = 0, big_wr = 0, big_done = -1;
  int          big_first_rd = -1, big_last_rd = -1, big_first_wr = -1;
  int          big_wr0_data = -1, big_wr0_addr = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency memory models
  always @(posedge clk) if (b.rd_en)  b.rd_data  <= mem[b.rd_addr[4:0]];
  always @(posedge clk) if (bb.rd_en) bb.rd_data <= bb.rd_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the small engine: every read and write is popped against the queues.
  always @(negedge clk) begin
    wexp_t w;
    if (b.rd_en === 1'b1) begin
      rd_cnt++;
      if (rq.size() == 0) begin
        vecs++; errs++;
        $display("FAIL rd_unexpected: read at addr %0d, none expected", b.rd_addr);
      end else begin
        chk("rd_addr", b.rd_addr, rq.pop_front());
      end
    end
    if (b.wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        vecs++; errs++;
        $display("FAIL wr_unexpected: write %0d at addr %0d, none expected", b.wr_data, b.wr_addr);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", b.wr_addr, w.addr);
        chk("wr_data", b.wr_data, w.data);
      end
    end
  end

  always @(negedge clk) begin
    if (bb.rd_en === 1'b1) begin
      big_rd++;
      if (big_rd == 1) big_first_rd = cyc - big_start;
      big_last_rd = cyc - big_start;
    end
    if (bb.wr_en === 1'b1) begin
      big_wr++;
      if (big_wr == 1) begin
        big_first_wr = cyc - big_start;
        big_wr0_data = bb.wr_data;
        big_wr0_addr = bb.wr_addr;
      end
    end
  end

  task automatic fill(input int kind);
    for (int i = 0; i < 32; i++)
      mem[i] = (kind == 0) ? 12'(i) : (kind == 1) ? 12'd4095 : 12'd0;
  endtask

  task automatic push_exp(input int d[8]);
    wexp_t w;
    for (int ch = 0; ch < 2; ch++)
      for (int i = 0; i < 16; i++) rq.push_back(ch * 16 + win_order[i]);
    for (int i = 0; i < 8; i++) begin
      w.addr = i; w.data = d[i];
      wq.push_back(w);
    end
  endtask

  task automatic kick(input logic m);
    rd_cnt = 0;
    @(posedge clk); #1 b.start = 1'b1; b.mode = m; start_cyc = cyc;
    @(posedge clk); #1 b.start = 1'b0;
    chk("busy_after_start", b.busy, 1);
  endtask

  task automatic wait_done(input int limit, output int l);
    l = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (b.done === 1'b1) begin
        l = cyc - start_cyc;
        break;
      end
    end
  endtask

  task automatic run_pass(input logic m, input int d[8], input bit poke);
    push_exp(d);
    kick(m);
    if (poke) begin
      repeat (10) @(posedge clk);
      #1 b.start = 1'b1; b.mode = ~m;
      @(posedge clk); #1 b.start = 1'b0;
    end
    wait_done(200, lat);
    chk("done_latency", lat, 35);
    chk("read_count", rd_cnt, 32);
    chk("busy_at_done", b.busy, 0);
    chk("rd_q_drained", rq.size(), 0);
    chk("wr_q_drained", wq.size(), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    b.start = 1'b0;  b.mode = 1'b0;
    bb.start = 1'b0; bb.mode = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {b.busy, b.done, b.rd_en, b.wr_en}, 0);
    chk("rst_rd_addr", b.rd_addr, 0);
    chk("rst_wr_addr", b.wr_addr, 0);
    chk("rst_wr_data", b.wr_data, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Default-size engine: timing relative to the start cycle
    @(posedge clk); #1 bb.start = 1'b1; big_start = cyc;
    @(posedge clk); #1 bb.start = 1'b0;
    chk("big_busy_c1", bb.busy, 1);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bb.done === 1'b1) begin
        big_done = cyc - big_start;
        break;
      end
    end
    chk("big_done_cycle", big_done, 787);
    chk("big_busy_at_done", bb.busy, 0);
    chk("big_reads", big_rd, 784);
    chk("big_first_rd", big_first_rd, 1);
    chk("big_last_rd", big_last_rd, 784);
    chk("big_first_wr", big_first_wr, 6);
    chk("big_writes", big_wr, 196);
    chk("big_wr0_addr", big_wr0_addr, 0);
    chk("big_wr0_data", big_wr0_data, 29);

    // Max, with a stray start and mode flip mid-pass
    fill(0);
    ed = '{5, 7, 13, 15, 21, 23, 29, 31};
    run_pass(1'b0, ed, 1'b1);

    // Average, started the cycle after done
    ed = '{2, 4, 10, 12, 18, 20, 26, 28};
    run_pass(1'b1, ed, 1'b0);

    fill(1);
    ed = '{4095, 4095, 4095, 4095, 4095, 4095, 4095, 4095};
    run_pass(1'b1, ed, 1'b0);

    fill(2);
    ed = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_pass(1'b0, ed, 1'b0);

    // Reset during read #9
    fill(0);
    ed = '{5, 7, 13, 15, 21, 23, 29, 31};
    push_exp(ed);
    kick(1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (rd_cnt >= 9) break;
    end
    chk("reached_rd9", rd_cnt, 9);
    rst_n = 1'b0;
    rq.delete();
    wq.delete();
    #1;
    chk("abort_ctrl", {b.busy, b.done, b.rd_en, b.wr_en}, 0);
    chk("abort_rd_addr", b.rd_addr, 0);
    chk("abort_wr_addr", b.wr_addr, 0);
    chk("abort_wr_data", b.wr_data, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_after_abort", {b.busy, b.done}, 0);
    chk("no_reads_after_abort", rd_cnt, 9);

    run_pass(1'b0, ed, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pool2d_engine.md
POOL2D_ENGINE -- requirements
Module: pool2d_engine

Interface
REQ-001 SHALL have parameter DW, default 12, unsigned pixel width.
REQ-002 SHALL have parameter IN_W, default 28, input map width (even, >=2).
REQ-003 SHALL have parameter IN_H, default 28, input map height (even, >=2).
REQ-004 SHALL have parameter CH, default 1, channel count (>=1).
REQ-005 SHALL have parameter AW, default 12, address width (>= clog2(CH*IN_W*IN_H)).
REQ-006 SHALL have clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have start  input  1  one-cycle request to pool the whole map.
REQ-009 SHALL have mode  input  1  0 = 2x2 max, 1 = 2x2 average.
REQ-010 SHALL have busy  output  1  high from start acceptance until done.
REQ-011 SHALL have done  output  1  one-cycle completion pulse.
REQ-012 SHALL have rd_en / rd_addr  output  1 / AW  input-memory read request and address.
REQ-013 SHALL have rd_data  input  DW  read data, valid exactly 1 cycle after rd_en.
REQ-014 SHALL have wr_en / wr_addr / wr_data  output  1 / AW / DW  output-memory write port.

Function
REQ-015 SHALL run FSM IDLE -> READ (on start in IDLE) -> DRAIN (after the last read issues) -> DONE (after the last write) -> IDLE.
REQ-016 SHALL latch mode at start acceptance; mode changes while busy SHALL have no effect.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL assert busy on the cycle after start is sampled and deassert it on the cycle done pulses.
REQ-019 SHALL issue one read per cycle, with no gaps, from the cycle after start acceptance; total reads = CH*(IN_H/2)*(IN_W/2)*4.
REQ-020 SHALL order reads channel-major, then output row oy, then output column ox; within each window: (2oy,2ox), (2oy,2ox+1), (2oy+1,2ox), (2oy+1,2ox+1).
REQ-021 SHALL compute rd_addr = c*IN_W*IN_H + y*IN_W + x, held stable in the rd_en cycle.
REQ-022 SHALL, in max mode, output the unsigned maximum of the 4 samples.
REQ-023 SHALL, in average mode, accumulate in DW+2 bits with no overflow and output sum>>2 (truncate toward zero).
REQ-024 SHALL assert wr_en for exactly one cycle, 2 cycles after the 4th read of a window (1 cycle of read latency + 1 register stage).
REQ-025 SHALL compute wr_addr = c*(IN_W/2)*(IN_H/2) + oy*(IN_W/2) + ox.
REQ-026 SHALL clear the accumulator at each window boundary, so no window contaminates the next, including across channel and row wrap.
REQ-027 SHALL pulse done exactly one cycle after the final wr_en; back-to-back start is accepted the cycle after done.
REQ-028 SHALL keep rd_en=0 and wr_en=0 in IDLE and DONE.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously force FSM=IDLE and all counters and the accumulator to 0.
REQ-030 SHALL hold busy, done, rd_en and wr_en at 0, and rd_addr, wr_addr and wr_data at 0, during reset.
REQ-031 SHALL abort an in-progress pass when reset is asserted mid-operation, with no further reads or writes after release until a new start.

Verification
REQ-032 Max mode, IN_W=IN_H=4, CH=1, input = addr value 0..15 -> writes 5,7,13,15 to addresses 0..3; done 1 cycle after the 4th write.
REQ-033 Average mode, same map -> writes 2,4,10,12 (sums 10,18,42,50 >>2).
REQ-034 Average mode, DW=12, all pixels 4095 -> every output 4095 (no overflow); max mode, all 0 -> every output 0.
REQ-035 CH=2, 4x4 -> reads 0..31 in window order, writes 8 outputs, channel 1 at wr_addr 4..7; start pulsed mid-pass -> no restart, read count exactly 32.
REQ-036 rst_n low at read #9 -> all outputs 0 immediately; after release, idle; new start -> full correct pass.
REQ-037 Timing check: start at cycle 0 -> rd_en cycles 1..4, first wr_en cycle 6, default 28x28 -> 784 reads, 196 writes, done at cycle 787.
